// File: rtl/dsp_pipe_ctrl.sv
// dsp_pipe_ctrl: issue/stall/bubble sequencer beside the DSP decode stage.
// Tracks in-flight write-back destinations, holds the pipe for multi-cycle
// MUL/MAC, and freezes fetch until an outstanding branch resolves.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_RUN      | normal issue; decode advances when no RAW hazard/flush
//   ST_MUL_WAIT | multi-cycle MUL/MAC in execute; scoreboard frozen, no issue
//   ST_BR_WAIT  | branch issued, waiting for execute to resolve it
module dsp_pipe_ctrl #(
  parameter int WB_DEPTH     = 3,
  parameter int MUL_LAT      = 2,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_dec_valid,
  input  logic [REG_ADDR_LEN-1:0] i_dec_src1_addr,
  input  logic [REG_ADDR_LEN-1:0] i_dec_src2_addr,
  input  logic [REG_ADDR_LEN-1:0] i_dec_src3_addr,
  input  logic [2:0]              i_dec_src_used,
  input  logic [REG_ADDR_LEN-1:0] i_dec_dest,
  input  logic                    i_dec_wb_en,
  input  logic                    i_dec_multi,
  input  logic                    i_dec_branch,
  input  logic                    i_br_resolved,
  input  logic                    i_br_taken,
  output logic                    o_issue,
  output logic                    o_stall_decode,
  output logic                    o_stall_fetch,
  output logic                    o_bubble,
  output logic                    o_flush,
  output logic                    o_hazard
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_BR_WAIT  = 2'd2
  } state_t;

  state_t                                   r_state;
  state_t                                   w_state_nxt;
  logic [CNT_W-1:0]                         r_mul_cnt;
  logic [CNT_W-1:0]                         w_mul_cnt_nxt;
  logic                                     r_flush;
  logic                                     w_flush_nxt;
  logic [WB_DEPTH-1:0]                      r_sb_valid;
  logic [WB_DEPTH-1:0][REG_ADDR_LEN-1:0]    r_sb_dest;
  logic                                     w_match;
  logic                                     w_hazard;
  logic                                     w_run;
  logic                                     w_issue;
  logic                                     w_stall_decode;

  // RAW detect: every entry is compared, including the one retiring this
  // cycle, because a same-cycle regfile write is not visible to decode.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (r_sb_valid[i]) begin
        if (i_dec_src_used[0] && (r_sb_dest[i] == i_dec_src1_addr)) w_match = 1'b1;
        if (i_dec_src_used[1] && (r_sb_dest[i] == i_dec_src2_addr)) w_match = 1'b1;
        if (i_dec_src_used[2] && (r_sb_dest[i] == i_dec_src3_addr)) w_match = 1'b1;
      end
    end
  end

  assign w_hazard       = i_dec_valid & w_match;
  assign w_run          = (r_state == ST_RUN);
  assign w_issue        = i_dec_valid & w_run & ~w_hazard & ~r_flush;
  assign w_stall_decode = i_dec_valid & ~w_issue & ~r_flush;

  assign o_issue        = w_issue;
  assign o_stall_decode = w_stall_decode;
  assign o_stall_fetch  = w_stall_decode | ~w_run;
  assign o_bubble       = ~w_issue;
  assign o_flush        = r_flush;
  assign o_hazard       = w_hazard;

  // Scoreboard shift register; frozen while a multi-cycle op occupies execute.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sb_valid <= '0;
      r_sb_dest  <= '0;
    end else if (r_state != ST_MUL_WAIT) begin
      r_sb_valid[0] <= w_issue & i_dec_wb_en;
      r_sb_dest[0]  <= w_issue ? i_dec_dest : '0;
      for (int i = 1; i < WB_DEPTH; i++) begin
        r_sb_valid[i] <= r_sb_valid[i-1];
        r_sb_dest[i]  <= r_sb_dest[i-1];
      end
    end
  end

  // Next-state logic: MUL hold down-counter and branch resolution.
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    w_flush_nxt   = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_issue) begin
          if (i_dec_multi && (MUL_LAT > 0)) begin
            w_state_nxt   = ST_MUL_WAIT;
            w_mul_cnt_nxt = CNT_W'(MUL_LAT);
          end else if (i_dec_branch) begin
            w_state_nxt = ST_BR_WAIT;
          end
        end
      end
      ST_MUL_WAIT: begin
        w_mul_cnt_nxt = r_mul_cnt - CNT_W'(1);
        if (r_mul_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        if (i_br_resolved) begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = i_br_taken;
        end
      end
      default: begin
        w_state_nxt   = ST_RUN;
        w_mul_cnt_nxt = '0;
      end
    endcase
  end

  // State, counter and flush pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_RUN;
      r_mul_cnt <= '0;
      r_flush   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      r_flush   <= w_flush_nxt;
    end
  end

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Bench for dsp_pipe_ctrl: directed scenarios with fixed expectations plus a
// randomized run against a transaction-level model (pending-write list with
// lifetimes, MUL hold count, branch-pending flag).
module tb_dsp_pipe_ctrl;
  localparam int WB_DEPTH = 3;
  localparam int MUL_LAT  = 2;
  localparam int RAL      = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           dec_valid, dec_wb_en, dec_multi, dec_branch, br_resolved, br_taken;
  logic [RAL-1:0] dec_src1_addr, dec_src2_addr, dec_src3_addr, dec_dest;
  logic [2:0]     dec_src_used;
  logic           o_issue, o_stall_decode, o_stall_fetch, o_bubble, o_flush, o_hazard;
  logic [5:0]     w_obs;

  int errors = 0;
  int checks = 0;

  // model state
  int  q_dest[$];
  int  q_life[$];
  int  m_mul_left;
  bit  m_br_wait;
  bit  m_flush;
  bit  e_issue, e_stall_decode, e_stall_fetch, e_bubble, e_flush, e_hazard;

  // observed outputs packed as {issue, stall_decode, stall_fetch, bubble, flush, hazard}
  assign w_obs = {o_issue, o_stall_decode, o_stall_fetch, o_bubble, o_flush, o_hazard};

  always #5 clk = ~clk;

  dsp_pipe_ctrl #(.WB_DEPTH(WB_DEPTH), .MUL_LAT(MUL_LAT), .REG_ADDR_LEN(RAL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(dec_valid),
    .i_dec_src1_addr(dec_src1_addr), .i_dec_src2_addr(dec_src2_addr),
    .i_dec_src3_addr(dec_src3_addr), .i_dec_src_used(dec_src_used),
    .i_dec_dest(dec_dest), .i_dec_wb_en(dec_wb_en), .i_dec_multi(dec_multi),
    .i_dec_branch(dec_branch), .i_br_resolved(br_resolved), .i_br_taken(br_taken),
    .o_issue(o_issue), .o_stall_decode(o_stall_decode), .o_stall_fetch(o_stall_fetch),
    .o_bubble(o_bubble), .o_flush(o_flush), .o_hazard(o_hazard)
  );

  task automatic set_in(input bit v, input int s1, input int s2, input int s3,
                        input bit [2:0] used, input int dest, input bit wb,
                        input bit multi, input bit br, input bit res, input bit tk);
    dec_valid     = v;
    dec_src1_addr = RAL'(s1);
    dec_src2_addr = RAL'(s2);
    dec_src3_addr = RAL'(s3);
    dec_src_used  = used;
    dec_dest      = RAL'(dest);
    dec_wb_en     = wb;
    dec_multi     = multi;
    dec_branch    = br;
    br_resolved   = res;
    br_taken      = tk;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    q_dest.delete();
    q_life.delete();
    m_mul_left = 0;
    m_br_wait  = 0;
    m_flush    = 0;
  endtask

  task automatic model_eval();
    bit run;
    run = (m_mul_left == 0) && !m_br_wait;
    e_hazard = 0;
    if (dec_valid) begin
      for (int j = 0; j < q_dest.size(); j++) begin
        if (dec_src_used[0] && q_dest[j] == int'(dec_src1_addr)) e_hazard = 1;
        if (dec_src_used[1] && q_dest[j] == int'(dec_src2_addr)) e_hazard = 1;
        if (dec_src_used[2] && q_dest[j] == int'(dec_src3_addr)) e_hazard = 1;
      end
    end
    e_flush        = m_flush;
    e_issue        = dec_valid && run && !e_hazard && !m_flush;
    e_stall_decode = dec_valid && !e_issue && !m_flush;
    e_stall_fetch  = e_stall_decode || !run;
    e_bubble       = !e_issue;
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit new_flush;
    model_eval();
    if (m_mul_left > 0) begin
      m_mul_left = m_mul_left - 1;
      m_flush    = 0;
    end else begin
      for (int j = q_life.size() - 1; j >= 0; j--) begin
        q_life[j] = q_life[j] - 1;
        if (q_life[j] == 0) begin
          q_life.delete(j);
          q_dest.delete(j);
        end
      end
      if (e_issue && dec_wb_en) begin
        q_dest.push_back(int'(dec_dest));
        q_life.push_back(WB_DEPTH);
      end
      new_flush = 0;
      if (m_br_wait && br_resolved) begin
        m_br_wait = 0;
        new_flush = br_taken;
      end
      if (e_issue && dec_multi && MUL_LAT > 0) m_mul_left = MUL_LAT;
      else if (e_issue && dec_branch) m_br_wait = 1;
      m_flush = new_flush;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (WB_DEPTH + MUL_LAT + 2) tick();
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    #2;
    checks++;
    if (w_obs !== 6'b000100) begin
      errors++;
      $display("FAIL reset_held: got %b want %b", w_obs, 6'b000100);
    end
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #2;
      checks++;
      if (w_obs !== 6'b000100) begin
        errors++;
        $display("FAIL reset_idle t%0d: got %b want %b", t, w_obs, 6'b000100);
      end
      tick();
    end
  endtask

  task automatic test_raw_stall();
    set_in(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
    #2;
    checks++;
    if (w_obs !== 6'b100000) begin
      errors++;
      $display("FAIL raw_t0: got %b want %b", w_obs, 6'b100000);
    end
    tick();
    set_in(1, 3, 0, 0, 3'b001, 9, 1, 0, 0, 0, 0);
    for (int t = 1; t <= WB_DEPTH; t++) begin
      #2;
      checks++;
      if (w_obs !== 6'b011101) begin
        errors++;
        $display("FAIL raw_stall t%0d: got %b want %b", t, w_obs, 6'b011101);
      end
      tick();
    end
    #2;
    checks++;
    if (w_obs !== 6'b100000) begin
      errors++;
      $display("FAIL raw_release: got %b want %b", w_obs, 6'b100000);
    end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 10, 11, 31, 3'b111, 3 + k, 1, 0, 0, 0, 0);
      #2;
      checks++;
      if (w_obs !== 6'b100000) begin
        errors++;
        $display("FAIL b2b k%0d: got %b want %b", k, w_obs, 6'b100000);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_mul();
    set_in(1, 1, 2, 31, 3'b111, 6, 1, 1, 0, 0, 0);
    #2;
    checks++;
    if (w_obs !== 6'b100000) begin
      errors++;
      $display("FAIL mul_t0: got %b want %b", w_obs, 6'b100000);
    end
    tick();
    set_in(1, 1, 0, 0, 3'b001, 7, 1, 0, 0, 0, 0);
    for (int t = 1; t <= MUL_LAT; t++) begin
      #2;
      checks++;
      if (w_obs !== 6'b011100) begin
        errors++;
        $display("FAIL mul_hold t%0d: got %b want %b", t, w_obs, 6'b011100);
      end
      tick();
    end
    #2;
    checks++;
    if (w_obs !== 6'b100000) begin
      errors++;
      $display("FAIL mul_next: got %b want %b", w_obs, 6'b100000);
    end
    tick();
    // MUL dest stayed in entry 0 across the hold, so it is still visible for two more cycles
    set_in(1, 0, 6, 0, 3'b010, 8, 1, 0, 0, 0, 0);
    for (int t = 4; t <= 5; t++) begin
      #2;
      checks++;
      if (w_obs !== 6'b011101) begin
        errors++;
        $display("FAIL mul_frozen t%0d: got %b want %b", t, w_obs, 6'b011101);
      end
      tick();
    end
    #2;
    checks++;
    if (w_obs !== 6'b100000) begin
      errors++;
      $display("FAIL mul_dep_issue: got %b want %b", w_obs, 6'b100000);
    end
    tick();
    drain();
  endtask

  task automatic test_branch(input bit taken);
    // resolve strobe coinciding with the branch issue must be ignored
    set_in(1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 1);
    #2;
    checks++;
    if (w_obs !== 6'b100000) begin
      errors++;
      $display("FAIL br%0d_t0: got %b want %b", taken, w_obs, 6'b100000);
    end
    tick();
    for (int t = 1; t <= 3; t++) begin
      set_in(1, 2, 0, 0, 3'b001, 2, 1, 0, 0, (t == 3), taken);
      #2;
      checks++;
      if (w_obs !== 6'b011100) begin
        errors++;
        $display("FAIL br%0d_wait t%0d: got %b want %b", taken, t, w_obs, 6'b011100);
      end
      tick();
    end
    set_in(1, 2, 0, 0, 3'b001, 2, 1, 0, 0, 0, 0);
    #2;
    checks++;
    if (taken) begin
      if (w_obs !== 6'b000110) begin
        errors++;
        $display("FAIL br1_flush t4: got %b want %b", w_obs, 6'b000110);
      end
      tick();
      #2;
      checks++;
      if (w_obs !== 6'b100000) begin
        errors++;
        $display("FAIL br1_issue t5: got %b want %b", w_obs, 6'b100000);
      end
    end else begin
      if (w_obs !== 6'b100000) begin
        errors++;
        $display("FAIL br0_issue t4: got %b want %b", w_obs, 6'b100000);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_reset_midop();
    for (int s = 0; s < 3; s++) begin
      set_in(1, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0);
      tick();
      set_in(1, 0, 0, 0, 3'b000, 0, 0, (s == 1), (s != 1), 0, 0);
      tick();
      if (s == 2) begin
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1);
        tick();
      end
      idle();
      #2;
      checks++;
      if (w_obs !== ((s == 2) ? 6'b000110 : 6'b001100)) begin
        errors++;
        $display("FAIL midop_pre s%0d: got %b want %b", s, w_obs,
                 ((s == 2) ? 6'b000110 : 6'b001100));
      end
      rst_n = 1'b0;
      model_reset();
      set_in(1, 7, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (w_obs !== 6'b100000) begin
        errors++;
        $display("FAIL midop_async s%0d: got %b want %b", s, w_obs, 6'b100000);
      end
      tick();
      rst_n = 1'b1;
      #2;
      checks++;
      if (w_obs !== 6'b100000) begin
        errors++;
        $display("FAIL midop_post s%0d: got %b want %b", s, w_obs, 6'b100000);
      end
      tick();
      drain();
    end
  endtask

  task automatic test_random(input int n);
    logic [5:0] exp;
    int kind;
    for (int c = 0; c < n; c++) begin
      kind = $urandom % 6;
      set_in(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), 3'($urandom), $urandom_range(0, 7), $urandom % 2,
             kind == 0, kind == 1, ($urandom % 3) == 0, $urandom % 2);
      #2;
      model_eval();
      exp = {e_issue, e_stall_decode, e_stall_fetch, e_bubble, e_flush, e_hazard};
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL random c%0d: got %b want %b", c, w_obs, exp);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_raw_stall();
    test_back_to_back();
    test_mul();
    test_branch(1'b1);
    test_branch(1'b0);
    test_reset_midop();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
